// File: rtl/con_pkg.sv
// Shared types and constants for the grid seeder slice.
//   state_e : seeding FSM states
//   dens_e  : cell density modes (fraction of cells alive)
//   ROT_*   : rotation amounts used to decorrelate bits when mixing
//   rotl32  : 32-bit rotate-left helper
package con_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DENS_50 = 2'd0,
    DENS_25 = 2'd1,
    DENS_12 = 2'd2,
    DENS_75 = 2'd3
  } dens_e;

  localparam int unsigned ROT_A = 32'd16;
  localparam int unsigned ROT_B = 32'd11;
  localparam int unsigned ROT_C = 32'd22;

  // Rotate a 32-bit word left by n (0 <= n < 32).
  function automatic logic [31:0] rotl32(input logic [31:0] w, input int unsigned n);
    return (w << n) | (w >> (32'd32 - n));
  endfunction

endpackage

// File: rtl/seed_mixer.sv
// Combinational density shaper for one grid row.
//   word  : raw LFSR word
//   mode  : density mode
//   mixed : shaped row bits, 1 = alive
// ANDing independent-looking rotations of the word lowers the alive
// fraction; ORing raises it.
module seed_mixer
  import con_pkg::*;
(
  input  logic [31:0] word,
  input  dens_e       mode,
  output logic [31:0] mixed
);

  // Select the density shaping for the current mode.
  always_comb begin
    mixed = word;
    case (mode)
      DENS_50: mixed = word;
      DENS_25: mixed = word & rotl32(word, ROT_A);
      DENS_12: mixed = word & rotl32(word, ROT_B) & rotl32(word, ROT_C);
      DENS_75: mixed = word | rotl32(word, ROT_A);
      default: mixed = word;
    endcase
  end

endmodule

// File: rtl/grid_seeder.sv
// Seeds the Game-of-Life grid with a random pattern, one row per write.
//   clk_i, reset_i : clock, synchronous active-high reset
//   lfsr_state_i   : free-running LFSR word
//   start_i        : begin a pass (IDLE only); density_i latched then
//   abort_i        : cancel a pass in progress
//   wr_valid_o / wr_ready_i / wr_addr_o / wr_data_o : row write port
//   busy_o         : pass in progress
//   done_o         : one-cycle pulse after the last row is accepted
module grid_seeder
  import con_pkg::*;
#(
  parameter int ROWS   = 32,
  parameter int STRIDE = 32,
  parameter int AW     = $clog2(ROWS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [31:0]   lfsr_state_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [1:0]    density_i,
  output logic          wr_valid_o,
  input  logic          wr_ready_i,
  output logic [AW-1:0] wr_addr_o,
  output logic [31:0]   wr_data_o,
  output logic          busy_o,
  output logic          done_o
);

  // Counter must be at least one bit wide even when STRIDE is 1.
  localparam int CW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(STRIDE - 1);
  localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);

  state_e        state_r, state_s;
  logic [AW-1:0] row_r, row_s;
  logic [CW-1:0] cnt_r, cnt_s;
  dens_e         mode_r, mode_s;
  logic [31:0]   mixed_s;
  logic          handshake_s;

  logic          valid_s, busy_s, done_s;
  logic [AW-1:0] addr_s;
  logic [31:0]   data_s;

  seed_mixer u_mixer (
    .word  (lfsr_state_i),
    .mode  (mode_r),
    .mixed (mixed_s)
  );

  assign handshake_s = wr_valid_o & wr_ready_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort wins over any handshake in the same cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) state_s = WAIT;
        else         state_s = IDLE;
      end
      WAIT: begin
        if (abort_i)                 state_s = IDLE;
        else if (cnt_r == {CW{1'b0}}) state_s = WRITE;
        else                         state_s = WAIT;
      end
      WRITE: begin
        if (abort_i) begin
          state_s = IDLE;
        end else if (handshake_s) begin
          if (row_r == ROW_LAST) state_s = DONE;
          else                   state_s = WAIT;
        end else begin
          state_s = WRITE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs.
  always_comb begin
    row_s   = row_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    addr_s  = wr_addr_o;
    data_s  = wr_data_o;
    // Output flags follow the state being entered so they are registered
    // yet line up with it.
    valid_s = (state_s == WRITE);
    busy_s  = (state_s != IDLE);
    done_s  = (state_s == DONE);
    case (state_r)
      IDLE: begin
        if (start_i) begin
          row_s  = {AW{1'b0}};
          cnt_s  = CNT_LOAD;
          mode_s = dens_e'(density_i);
        end else begin
          row_s  = row_r;
        end
      end
      WAIT: begin
        if (state_s == WRITE) begin
          // Row word captured once; held until the store accepts it.
          addr_s = row_r;
          data_s = mixed_s;
        end else if (cnt_r != {CW{1'b0}}) begin
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_s = cnt_r;
        end
      end
      WRITE: begin
        if (state_s == WAIT) begin
          row_s = row_r + {{(AW-1){1'b0}}, 1'b1};
          cnt_s = CNT_LOAD;
        end else begin
          row_s = row_r;
        end
      end
      DONE:    row_s = row_r;
      default: row_s = row_r;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      row_r      <= {AW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      mode_r     <= DENS_50;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= {AW{1'b0}};
      wr_data_o  <= 32'h0000_0000;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      row_r      <= row_s;
      cnt_r      <= cnt_s;
      mode_r     <= mode_s;
      wr_valid_o <= valid_s;
      wr_addr_o  <= addr_s;
      wr_data_o  <= data_s;
      busy_o     <= busy_s;
      done_o     <= done_s;
    end
  end

endmodule
